// File: rtl/univ_shift_reg.sv
// Universal WIDTH-bit shift register: eight single-cycle operations plus an
// autonomous burst mode that repeats one shift a programmed number of times.
module univ_shift_reg #(
    parameter int                 WIDTH     = 8,
    parameter logic [WIDTH-1:0]   RESET_VAL = '0,
    localparam int                CW        = $clog2(WIDTH + 1)
) (
    input  logic             Clk,
    input  logic             reset,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] D,
    input  logic             SinR,
    input  logic             SinL,
    input  logic             start,
    input  logic [CW-1:0]    count,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] Qb,
    output logic             SoL,
    output logic             SoR,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [2:0]    M_HOLD = 3'b000;
    localparam logic [2:0]    M_LOAD = 3'b001;
    localparam logic [2:0]    M_SHL  = 3'b010;
    localparam logic [2:0]    M_SHR  = 3'b011;
    localparam logic [2:0]    M_ROL  = 3'b100;
    localparam logic [2:0]    M_ROR  = 3'b101;
    localparam logic [2:0]    M_ASR  = 3'b110;
    localparam logic [2:0]    M_CLR  = 3'b111;
    localparam logic [CW-1:0] MAX_CNT = CW'(WIDTH);

    state_t           state_r, state_s;
    logic [WIDTH-1:0] q_r, q_s;
    logic [2:0]       mode_r, mode_s;
    logic [CW-1:0]    cnt_r, cnt_s;
    logic [CW-1:0]    count_clamped_s;
    logic             burst_req_s;

    function automatic logic is_shift(input logic [2:0] op);
        return (op >= M_SHL) && (op <= M_ASR);
    endfunction

    function automatic logic [WIDTH-1:0] apply_op(
        input logic [2:0]       op,
        input logic [WIDTH-1:0] q,
        input logic [WIDTH-1:0] d,
        input logic             sin_r,
        input logic             sin_l
    );
        logic [WIDTH-1:0] r;
        case (op)
            M_HOLD:  r = q;
            M_LOAD:  r = d;
            M_SHL:   r = {q[WIDTH-2:0], sin_r};
            M_SHR:   r = {sin_l, q[WIDTH-1:1]};
            M_ROL:   r = {q[WIDTH-2:0], q[WIDTH-1]};
            M_ROR:   r = {q[0], q[WIDTH-1:1]};
            M_ASR:   r = {q[WIDTH-1], q[WIDTH-1:1]};
            M_CLR:   r = RESET_VAL;
            default: r = q;
        endcase
        return r;
    endfunction

    // Burst request qualification and count clamping
    always_comb begin
        burst_req_s = start && is_shift(mode);
        if (count > MAX_CNT) begin
            count_clamped_s = MAX_CNT;
        end else begin
            count_clamped_s = count;
        end
    end

    // Next-state and datapath selection; en=0 leaves everything at its current value
    always_comb begin
        state_s = state_r;
        q_s     = q_r;
        mode_s  = mode_r;
        cnt_s   = cnt_r;
        if (en) begin
            case (state_r)
                IDLE: begin
                    if (burst_req_s) begin
                        mode_s = mode;
                        cnt_s  = count_clamped_s;
                        if (count_clamped_s == {CW{1'b0}}) begin
                            state_s = DONE;
                        end else begin
                            state_s = RUN;
                        end
                    end else begin
                        q_s = apply_op(mode, q_r, D, SinR, SinL);
                    end
                end
                RUN: begin
                    q_s   = apply_op(mode_r, q_r, D, SinR, SinL);
                    cnt_s = cnt_r - CW'(1);
                    if (cnt_r == CW'(1)) begin
                        state_s = DONE;
                    end else begin
                        state_s = RUN;
                    end
                end
                DONE: begin
                    // Not busy here, but a burst request is dropped rather than queued
                    state_s = IDLE;
                    if (burst_req_s) begin
                        q_s = q_r;
                    end else begin
                        q_s = apply_op(mode, q_r, D, SinR, SinL);
                    end
                end
                default: begin
                    state_s = IDLE;
                end
            endcase
        end else begin
            state_s = state_r;
        end
    end

    // State registers with synchronous reset that overrides en
    always_ff @(posedge Clk) begin
        if (reset) begin
            state_r <= IDLE;
            q_r     <= RESET_VAL;
            mode_r  <= M_HOLD;
            cnt_r   <= {CW{1'b0}};
        end else begin
            state_r <= state_s;
            q_r     <= q_s;
            mode_r  <= mode_s;
            cnt_r   <= cnt_s;
        end
    end

    assign Q    = q_r;
    assign Qb   = ~q_r;
    assign SoL  = q_r[WIDTH-1];
    assign SoR  = q_r[0];
    assign busy = (state_r == RUN);
    assign done = (state_r == DONE);

endmodule

// File: tb/tb_univ_shift_reg.sv
// Directed self-checking bench for univ_shift_reg (WIDTH=8, RESET_VAL=0).
module tb_univ_shift_reg;

    localparam int WIDTH = 8;
    localparam int CW    = $clog2(WIDTH + 1);

    logic             Clk = 1'b0;
    logic             reset, en, SinR, SinL, start;
    logic [2:0]       mode;
    logic [WIDTH-1:0] D;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] Q, Qb;
    logic             SoL, SoR, busy, done;

    int pass_cnt  = 0;
    int fail_cnt  = 0;
    int total_cnt = 0;
    int n;

    univ_shift_reg #(.WIDTH(WIDTH), .RESET_VAL(8'h00)) dut (
        .Clk(Clk), .reset(reset), .en(en), .mode(mode), .D(D),
        .SinR(SinR), .SinL(SinL), .start(start), .count(count),
        .Q(Q), .Qb(Qb), .SoL(SoL), .SoR(SoR), .busy(busy), .done(done)
    );

    always #5 Clk = ~Clk;

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) begin
            pass_cnt++;
        end else begin
            fail_cnt++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic load(input logic [7:0] val);
        mode = 3'b001; D = val; start = 1'b0;
        step();
    endtask

    task automatic single(input logic [2:0] m);
        mode = m; start = 1'b0;
        step();
        mode = 3'b000;
    endtask

    initial begin
        reset = 1'b1; en = 1'b1; mode = 3'b000; D = 8'h00;
        SinR = 1'b0; SinL = 1'b0; start = 1'b0; count = '0;
        step();
        check("rst_q", 32'(Q), 32'h00);
        check("rst_qb", 32'(Qb), 32'hFF);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_done", 32'(done), 32'h0);

        reset = 1'b0;
        load(8'h5A);
        check("load_5a", 32'(Q), 32'h5A);
        check("sol_sor", 32'({SoL, SoR}), 32'h0);
        en = 1'b0; reset = 1'b1;
        step();
        check("rst_en0", 32'(Q), 32'h00);
        reset = 1'b0; en = 1'b1;

        load(8'hA5); single(3'b100);
        check("rol", 32'(Q), 32'h4B);
        load(8'hA5); single(3'b101);
        check("ror", 32'(Q), 32'hD2);
        load(8'h90); single(3'b110);
        check("asr", 32'(Q), 32'hC8);
        load(8'h81); SinR = 1'b1; single(3'b010); SinR = 1'b0;
        check("shl", 32'(Q), 32'h03);
        load(8'h81); SinL = 1'b0; single(3'b011);
        check("shr", 32'(Q), 32'h40);
        single(3'b111);
        check("clr", 32'(Q), 32'h00);

        // Burst of 3 left shifts; mode/D disturbed while busy
        load(8'h01);
        start = 1'b1; mode = 3'b010; count = 4'd3; SinR = 1'b0;
        step();
        check("b_e0_q", 32'(Q), 32'h01);
        check("b_e0_busy", 32'(busy), 32'h1);
        start = 1'b0; mode = 3'b001; D = 8'hFF;
        step();
        check("b_e1_q", 32'(Q), 32'h02);
        check("b_e1_busy", 32'(busy), 32'h1);
        step();
        check("b_e2_q", 32'(Q), 32'h04);
        mode = 3'b000;
        step();
        check("b_e3_q", 32'(Q), 32'h08);
        check("b_e3_busy", 32'(busy), 32'h0);
        check("b_e3_done", 32'(done), 32'h1);
        step();
        check("b_post_done", 32'(done), 32'h0);
        check("b_post_q", 32'(Q), 32'h08);

        // Zero-length burst
        load(8'h33);
        start = 1'b1; mode = 3'b011; count = 4'd0;
        step();
        check("z_q", 32'(Q), 32'h33);
        check("z_busy", 32'(busy), 32'h0);
        check("z_done", 32'(done), 32'h1);
        start = 1'b0; mode = 3'b000;
        step();
        check("z_done_end", 32'(done), 32'h0);

        // Oversized count clamps to WIDTH shifts
        load(8'h00);
        start = 1'b1; mode = 3'b010; count = 4'd15; SinR = 1'b1;
        step();
        start = 1'b0; mode = 3'b000;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            n++;
            if (done) break;
        end
        check("clamp_shifts", 32'(n), 32'd8);
        check("clamp_q", 32'(Q), 32'hFF);
        check("clamp_done", 32'(done), 32'h1);
        SinR = 1'b0;
        step();

        // Start with a non-shift mode is a plain load
        start = 1'b1; mode = 3'b001; D = 8'h3C; count = 4'd3;
        step();
        start = 1'b0; mode = 3'b000;
        check("ns_q", 32'(Q), 32'h3C);
        check("ns_busy", 32'(busy), 32'h0);
        check("ns_done", 32'(done), 32'h0);

        // Pause: en low for 2 cycles after E1 stretches busy to 5 cycles
        load(8'h01);
        start = 1'b1; mode = 3'b010; count = 4'd3;
        step();
        start = 1'b0; mode = 3'b000;
        n = busy ? 1 : 0;
        step();
        if (busy) n++;
        en = 1'b0;
        step(); if (busy) n++;
        step(); if (busy) n++;
        check("p_hold_q", 32'(Q), 32'h02);
        en = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            if (busy) n++;
            if (done) break;
        end
        check("p_busy_len", 32'(n), 32'd5);
        check("p_q", 32'(Q), 32'h08);
        check("p_done", 32'(done), 32'h1);
        step();

        // Abort by reset at E2, then immediate new burst
        load(8'h01);
        start = 1'b1; mode = 3'b010; count = 4'd3;
        step();
        start = 1'b0; mode = 3'b000;
        step();
        check("a_e1_q", 32'(Q), 32'h02);
        reset = 1'b1;
        step();
        check("a_q", 32'(Q), 32'h00);
        check("a_busy", 32'(busy), 32'h0);
        check("a_done", 32'(done), 32'h0);
        reset = 1'b0;
        start = 1'b1; mode = 3'b010; count = 4'd2;
        step();
        check("a_new_busy", 32'(busy), 32'h1);
        check("a_new_nodone", 32'(done), 32'h0);
        start = 1'b0; mode = 3'b000;
        step();
        step();
        check("a_new_done", 32'(done), 32'h1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
